mul_share_arb: RTL and testbench

- Round-robin arbiter that shares one sequential shift-add multiplier among N_REQ requesters.
- Latches the winner's operands and pulses the multiplier's start input.
- Tracks the multiplier's ready handshake through its busy phase and back to idle.
- Returns the product to the winner with a one-cycle done pulse.
- Sits between client datapaths and a single multiplier instance with a start/ready/product interface.

---
 rtl/mul_share_arb.sv | 164 ++++++++++++++++
 tb/tb_mul_share_arb.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter sharing one sequential multiplier among
// N_REQ requesters. The winner's operands are registered and handed to the
// multiplier with a one-cycle start pulse. The product is returned with a
// one-cycle done pulse. Optional watchdog: define MUL_SHARE_ARB_TIMEOUT_EN.
module mul_share_arb #(
  parameter int DP_WIDTH = 5,
  parameter int N_REQ    = 4,
  parameter int IDX_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DP_WIDTH-1:0] opa,
  input  logic [N_REQ*DP_WIDTH-1:0] opb,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [2*DP_WIDTH-1:0]     result,
  output logic                      err,
  output logic                      busy,
  output logic                      mul_start,
  output logic [DP_WIDTH-1:0]       mul_multiplier,
  output logic [DP_WIDTH-1:0]       mul_multiplicand,
  input  logic [2*DP_WIDTH-1:0]     mul_product,
  input  logic                      mul_ready
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_LOW  = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] RESP      = 3'd4;

  // One extra bit so rr + offset can exceed N_REQ-1 before wrapping.
  localparam int CW = IDX_W + 1;

  logic [2:0]          state;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    rr;
  logic [IDX_W-1:0]    winner;
  logic                found;
  logic [CW-1:0]       cand;
  logic [DP_WIDTH-1:0] sel_a;
  logic [DP_WIDTH-1:0] sel_b;
  logic [N_REQ-1:0]    idx_onehot;

`ifdef MUL_SHARE_ARB_TIMEOUT_EN
  localparam int WD_LIMIT = 4 * DP_WIDTH + 4;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wdog;
  logic            wdog_hit;
  logic            err_q;

  assign wdog_hit = (wdog == WD_W'(WD_LIMIT));
  assign err      = err_q;
`else
  assign err = 1'b0;
`endif

  // Pick the first requester at or after the round-robin pointer, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr} + CW'(k);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  assign sel_a      = opa[winner*DP_WIDTH +: DP_WIDTH];
  assign sel_b      = opb[winner*DP_WIDTH +: DP_WIDTH];
  assign idx_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;

  // Pulses are decoded from registered state only, so they are glitch-free.
  assign busy      = (state != IDLE);
  assign mul_start = (state == ISSUE);
  assign gnt       = (state == ISSUE) ? idx_onehot : '0;
  assign done      = (state == RESP)  ? idx_onehot : '0;

`ifdef MUL_SHARE_ARB_TIMEOUT_EN
  // Watchdog restarts at each issue and counts while the multiplier is busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog <= '0;
    end else if (state == ISSUE) begin
      wdog <= '0;
    end else if ((state == WAIT_LOW || state == WAIT_DONE) && !wdog_hit) begin
      wdog <= wdog + 1'b1;
    end
  end
`endif

  // Arbitration FSM: grant, start the multiplier, follow ready low then high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      idx              <= '0;
      rr               <= '0;
      result           <= '0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
`ifdef MUL_SHARE_ARB_TIMEOUT_EN
      err_q            <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found && mul_ready) begin
            idx              <= winner;
            mul_multiplier   <= sel_a;
            mul_multiplicand <= sel_b;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          rr    <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
          state <= WAIT_LOW;
`ifdef MUL_SHARE_ARB_TIMEOUT_EN
          err_q <= 1'b0;
`endif
        end
        WAIT_LOW: begin
          if (!mul_ready) begin
            state <= WAIT_DONE;
          end
`ifdef MUL_SHARE_ARB_TIMEOUT_EN
          if (wdog_hit) begin
            result <= '0;
            err_q  <= 1'b1;
            state  <= RESP;
          end
`endif
        end
        WAIT_DONE: begin
          if (mul_ready) begin
            result <= mul_product;
            state  <= RESP;
`ifdef MUL_SHARE_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
          end else if (wdog_hit) begin
            result <= '0;
            err_q  <= 1'b1;
            state  <= RESP;
`endif
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed scoreboard bench for mul_share_arb with a
// behavioural shift-add multiplier stub (ready drops one cycle after start,
// stays low 2*DP_WIDTH cycles). Timeout case runs when
// MUL_SHARE_ARB_TIMEOUT_EN is defined.
module tb_mul_share_arb;

  localparam int DPW = 5;
  localparam int NR  = 4;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR*DPW-1:0] opa;
  logic [NR*DPW-1:0] opb;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   done;
  logic [2*DPW-1:0] result;
  logic            err;
  logic            busy;
  logic            mul_start;
  logic [DPW-1:0]  mul_multiplier;
  logic [DPW-1:0]  mul_multiplicand;
  logic [2*DPW-1:0] mul_product;
  logic            mul_ready;

  typedef struct packed {
    logic [1:0]       idx;
    logic [2*DPW-1:0] res;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   compared;
  int   mismatched;
  int   cyc;
  logic [DPW-1:0] av [NR];
  logic [DPW-1:0] bv [NR];

  // Multiplier stub state
  int   stub_cnt;
  logic stub_hold;
  logic stub_hang;
  logic [2*DPW-1:0] stub_prod;

  mul_share_arb #(.DP_WIDTH(DPW), .N_REQ(NR), .IDX_W(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .opa              (opa),
    .opb              (opb),
    .gnt              (gnt),
    .done             (done),
    .result           (result),
    .err              (err),
    .busy             (busy),
    .mul_start        (mul_start),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_product      (mul_product),
    .mul_ready        (mul_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub multiplier: latches operands on start, busy for 2*DPW cycles.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      stub_cnt  <= 0;
      stub_prod <= '0;
    end else if (stub_cnt == 0) begin
      if (mul_start) begin
        stub_cnt  <= 2 * DPW;
        stub_prod <= {5'b0, mul_multiplier} * {5'b0, mul_multiplicand};
      end
    end else if (!stub_hang) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  assign mul_ready   = (stub_cnt == 0) && !stub_hold;
  assign mul_product = stub_prod;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse is compared against the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && done !== '0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_done_idx", 32'(done), 32'(4'(1) << e.idx));
        check("sb_result", 32'(result), 32'(e.res));
        check("sb_err", 32'(err), 32'(e.err));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DPW-1:0] a, input logic [DPW-1:0] b);
    av[i] = a;
    bv[i] = b;
    opa[i*DPW +: DPW] = a;
    opb[i*DPW +: DPW] = b;
  endtask

  function automatic logic [2*DPW-1:0] prod(input logic [DPW-1:0] a, input logic [DPW-1:0] b);
    return {5'b0, a} * {5'b0, b};
  endfunction

  task automatic wait_gnt(output int gidx, output int gcyc, output bit ok);
    gidx = -1;
    gcyc = 0;
    ok   = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      step(1);
      if (gnt !== '0) begin
        ok   = 1'b1;
        gcyc = cyc;
        for (int k = 0; k < NR; k++) if (gnt[k]) gidx = k;
      end
    end
  endtask

  task automatic expect_grant(input string tag, input int exp_idx, output int gcyc);
    int  gidx;
    bit  ok;
    exp_q.push_back('{idx: 2'(exp_idx), res: prod(av[exp_idx], bv[exp_idx]), err: 1'b0});
    wait_gnt(gidx, gcyc, ok);
    check({tag, "_seen"}, 32'(ok), 32'd1);
    check({tag, "_idx"}, 32'(gidx), 32'(exp_idx));
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 80 && !ok; n++) begin
      step(1);
      if (busy === 1'b0 && mul_ready === 1'b1) ok = 1'b1;
    end
    check({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  // Drives one isolated request and checks the exact cycle-by-cycle latency.
  task automatic latency_txn(input string tag, input int i, input logic [DPW-1:0] a, input logic [DPW-1:0] b);
    logic [NR-1:0] oh;
    oh = 4'(1) << i;
    set_op(i, a, b);
    req = oh;
    exp_q.push_back('{idx: 2'(i), res: prod(a, b), err: 1'b0});
    step(1);
    check({tag, "_gnt_c1"}, 32'(gnt), 32'(oh));
    check({tag, "_start_c1"}, 32'(mul_start), 32'd1);
    check({tag, "_mplier"}, 32'(mul_multiplier), 32'(a));
    check({tag, "_mcand"}, 32'(mul_multiplicand), 32'(b));
    req = '0;
    step(11);
    check({tag, "_done_c12"}, 32'(done), 32'd0);
    check({tag, "_busy_c12"}, 32'(busy), 32'd1);
    step(1);
    check({tag, "_done_c13"}, 32'(done), 32'(oh));
    check({tag, "_result_c13"}, 32'(result), 32'(prod(a, b)));
    check({tag, "_err_c13"}, 32'(err), 32'd0);
    step(1);
    check({tag, "_busy_c14"}, 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int gc;
    int prev;
    int order [5];
    int gidx;
    bit ok;
    bit seen;

    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    stub_hold  = 1'b0;
    stub_hang  = 1'b0;
    req        = '0;
    opa        = '0;
    opb        = '0;
    for (int i = 0; i < NR; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end
    reset = 1'b0;

    // Reset state
    step(2);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(mul_start), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mplier", 32'(mul_multiplier), 32'd0);
    reset = 1'b1;
    step(1);

    // Single request with exact latency
    latency_txn("single", 0, 5'd13, 5'd11);

    // All requesters held: order 0,1,2,3,0, spaced 14 cycles
    apply_reset();
    for (int i = 0; i < NR; i++) set_op(i, 5'(i + 3), 5'(2 * i + 5));
    req = 4'b1111;
    order = '{0, 1, 2, 3, 0};
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      expect_grant("rr", order[n], gc);
      if (n > 0) check("rr_spacing", 32'(gc - prev), 32'd14);
      prev = gc;
      if (n == 4) req = '0;
    end
    wait_idle("rr");

    // Fairness: pointer sits after 2, so 0 wins only when 3 is idle
    req = 4'b0100;
    expect_grant("fair_a", 2, gc);
    req = 4'b0101;
    expect_grant("fair_b", 0, gc);
    req = 4'b0100;
    expect_grant("fair_c", 2, gc);
    req = 4'b1101;
    expect_grant("fair_d", 3, gc);
    req = '0;
    wait_idle("fair");

    // Multiplier not ready: nothing is granted until it is
    stub_hold = 1'b1;
    set_op(0, 5'd3, 5'd4);
    req = 4'b0001;
    step(6);
    check("notready_gnt", 32'(gnt), 32'd0);
    check("notready_busy", 32'(busy), 32'd0);
    stub_hold = 1'b0;
    expect_grant("notready_after", 0, gc);
    req = '0;
    wait_idle("notready");

    // Edge operands
    set_op(1, 5'd31, 5'd31);
    req = 4'b0010;
    expect_grant("max", 1, gc);
    req = '0;
    wait_idle("max");
    set_op(1, 5'd0, 5'd17);
    req = 4'b0010;
    expect_grant("zero", 1, gc);
    req = '0;
    wait_idle("zero");
    set_op(1, 5'd1, 5'd31);
    req = 4'b0010;
    expect_grant("one", 1, gc);
    req = '0;
    wait_idle("one");

    // Reset mid-operation: abandoned, no done, outputs clear at once
    set_op(1, 5'd9, 5'd9);
    req = 4'b0010;
    wait_gnt(gidx, gc, ok);
    check("midrst_gnt_seen", 32'(ok), 32'd1);
    req = '0;
    step(5);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_start", 32'(mul_start), 32'd0);
    check("midrst_mplier", 32'(mul_multiplier), 32'd0);
    step(2);
    reset = 1'b1;
    step(1);
    latency_txn("after_rst", 1, 5'd7, 5'd6);

`ifdef MUL_SHARE_ARB_TIMEOUT_EN
    // Hung multiplier: watchdog ends the transaction with err and result 0
    stub_hang = 1'b1;
    set_op(2, 5'd5, 5'd5);
    req = 4'b0100;
    exp_q.push_back('{idx: 2'd2, res: '0, err: 1'b1});
    wait_gnt(gidx, gc, ok);
    check("to_gnt_seen", 32'(ok), 32'd1);
    req = '0;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      step(1);
      if (done !== '0) seen = 1'b1;
    end
    check("to_done_seen", 32'(seen), 32'd1);
    check("to_err", 32'(err), 32'd1);
    check("to_result", 32'(result), 32'd0);
    stub_hang = 1'b0;
    wait_idle("to");
    latency_txn("to_next", 2, 5'd6, 5'd5);
`else
    seen = 1'b0;
`endif

    step(5);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
